wb_stage: RTL and testbench

Writeback stage and architectural register file, directly downstream of the MEM/WB pipeline register. Decodes the 16-bit instruction latched in MEM/WB and selects the ALU result or memory read data. Writes the register file through a single write port and serves the two decode-stage read ports with same-cycle write bypass. 32-bit MUL/DIV results need two writes, so the stage sequences them over two cycles and stalls the pipeline for one.

---
 rtl/wb_stage.sv | 112 +++++++++++
 tb/tb_wb_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage and architectural register file with same-cycle write bypass.
// Two-word MUL/DIV results are written over two cycles, stalling upstream for one.
module wb_stage #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned HI_REG = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] read_data_i,
  input  logic [31:0] alu_result_i,
  input  logic [3:0]  rs_addr_i,
  input  logic [3:0]  rt_addr_i,
  output logic [15:0] rs_data_o,
  output logic [15:0] rt_data_o,
  output logic        stall_o,
  output logic        wr_en_o,
  output logic [3:0]  wr_addr_o,
  output logic [15:0] wr_data_o
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  typedef enum logic {ST_LO, ST_HI} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   regs_q [NREG];

  logic [3:0]      opcode;
  logic [AW-1:0]   rd;
  logic            unused_fields;

  assign opcode        = instr_i[15:12];
  assign rd            = instr_i[11:8];
  assign unused_fields = ^instr_i[7:0];

  // State and high-half holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LO;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
    end
  end

  // Next state and write-port decode; everything forced idle while in reset
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    stall_o   = 1'b0;
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (rst) begin
      case (state_q)
        ST_LO: begin
          if (valid_i) begin
            if (!opcode[3]) begin
              wr_en_o   = 1'b1;
              wr_addr_o = rd;
              wr_data_o = alu_result_i[15:0];
            end else if (opcode == 4'b1000) begin
              wr_en_o   = 1'b1;
              wr_addr_o = rd;
              wr_data_o = read_data_i;
            end else if (opcode == 4'b1010 || opcode == 4'b1011) begin
              wr_en_o   = 1'b1;
              wr_addr_o = rd;
              wr_data_o = alu_result_i[15:0];
              stall_o   = 1'b1;
              hi_d      = alu_result_i[31:16];
              state_d   = ST_HI;
            end
          end
        end
        ST_HI: begin
          wr_en_o   = 1'b1;
          wr_addr_o = AW'(HI_REG);
          wr_data_o = hi_q;
          state_d   = ST_LO;
        end
        default: state_d = ST_LO;
      endcase
    end
  end

  // Register array; R0 is never stored so it always reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en_o && wr_addr_o != '0) begin
      regs_q[wr_addr_o] <= wr_data_o;
    end
  end

  always_comb begin
    rs_data_o = '0;
    rt_data_o = '0;
    if (rs_addr_i != '0) begin
      rs_data_o = (wr_en_o && wr_addr_o == rs_addr_i) ? wr_data_o : regs_q[rs_addr_i];
    end
    if (rt_addr_i != '0) begin
      rt_data_o = (wr_en_o && wr_addr_o == rt_addr_i) ? wr_data_o : regs_q[rt_addr_i];
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, reset-in-HI sequence, and
// randomized traffic against a register-file model with a pending-write queue.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [15:0] instr_i;
  logic [15:0] read_data_i;
  logic [31:0] alu_result_i;
  logic [3:0]  rs_addr_i, rt_addr_i;
  logic [15:0] rs_data_o, rt_data_o;
  logic        stall_o, wr_en_o;
  logic [3:0]  wr_addr_o;
  logic [15:0] wr_data_o;

  wb_stage #(.NREG(16), .HI_REG(15)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i),
    .read_data_i(read_data_i), .alu_result_i(alu_result_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .stall_o(stall_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] rdata;
    logic [31:0] alu;
    logic [3:0]  rs, rt;
    logic        wen;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        stall;
    logic [15:0] rsd, rtd;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] mregs [16];
  wr_t         pend [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] rd_d,
                       input logic [31:0] alu, input logic [3:0] rs, input logic [3:0] rt);
    valid_i = v; instr_i = ins; read_data_i = rd_d; alu_result_i = alu;
    rs_addr_i = rs; rt_addr_i = rt;
  endtask

  task automatic chk_outs(input string tag, input logic wen, input logic [3:0] waddr,
                          input logic [15:0] wdata, input logic stall,
                          input logic [15:0] rsd, input logic [15:0] rtd);
    chk({tag, ".wr_en"}, 32'(wr_en_o), 32'(wen));
    chk({tag, ".wr_addr"}, 32'(wr_addr_o), 32'(waddr));
    chk({tag, ".wr_data"}, 32'(wr_data_o), 32'(wdata));
    chk({tag, ".stall"}, 32'(stall_o), 32'(stall));
    chk({tag, ".rs_data"}, 32'(rs_data_o), 32'(rsd));
    chk({tag, ".rt_data"}, 32'(rt_data_o), 32'(rtd));
  endtask

  function automatic logic [15:0] mread(input logic [3:0] a, input logic wen,
                                        input logic [3:0] waddr, input logic [15:0] wdata);
    if (a == 4'd0) return 16'h0;
    if (wen && waddr == a) return wdata;
    return mregs[a];
  endfunction

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd);
    return {op, rd, 8'h00};
  endfunction

  vec_t vecs [12];

  initial begin
    // Directed vectors, applied back to back from a fresh reset
    vecs[0]  = '{1, ins(4'h0, 3), 16'h0, 32'h0001_1234, 3, 0,  1, 3,  16'h1234, 0, 16'h1234, 16'h0};
    vecs[1]  = '{1, ins(4'h8, 5), 16'hBEEF, 32'hFFFF_0000, 3, 5, 1, 5, 16'hBEEF, 0, 16'h1234, 16'hBEEF};
    vecs[2]  = '{1, ins(4'hA, 2), 16'h0, 32'hABCD_1357, 2, 15, 1, 2, 16'h1357, 1, 16'h1357, 16'h0};
    vecs[3]  = '{1, ins(4'hA, 2), 16'h0, 32'hABCD_1357, 2, 15, 1, 15, 16'hABCD, 0, 16'h1357, 16'hABCD};
    vecs[4]  = '{1, ins(4'hB, 15), 16'h0, 32'h0003_0007, 15, 2, 1, 15, 16'h0007, 1, 16'h0007, 16'h1357};
    vecs[5]  = '{1, ins(4'hB, 15), 16'h0, 32'h0003_0007, 15, 2, 1, 15, 16'h0003, 0, 16'h0003, 16'h1357};
    vecs[6]  = '{1, ins(4'h1, 0), 16'h0, 32'h0000_5555, 0, 15, 1, 0, 16'h5555, 0, 16'h0, 16'h0003};
    vecs[7]  = '{1, ins(4'h9, 3), 16'h7777, 32'h0000_9999, 3, 0, 0, 0, 16'h0, 0, 16'h1234, 16'h0};
    vecs[8]  = '{0, ins(4'h0, 3), 16'h0, 32'h0000_1111, 3, 5, 0, 0, 16'h0, 0, 16'h1234, 16'hBEEF};
    vecs[9]  = '{1, ins(4'hF, 4), 16'h0, 32'h0000_2222, 4, 2, 0, 0, 16'h0, 0, 16'h0, 16'h1357};
    vecs[10] = '{1, ins(4'hC, 6), 16'h0, 32'h0000_3333, 6, 15, 0, 0, 16'h0, 0, 16'h0, 16'h0003};
    vecs[11] = '{1, ins(4'h7, 1), 16'h0, 32'hFFFF_8001, 1, 1, 1, 1, 16'h8001, 0, 16'h8001, 16'h8001};

    // Reset: outputs idle and reads zero even with a live writing op present
    rst = 1'b0;
    drive(1, ins(4'h0, 3), 16'h0, 32'h0000_4444, 3, 3);
    #7;
    chk_outs("reset", 0, 0, 16'h0, 0, 16'h0, 16'h0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].instr, vecs[i].rdata, vecs[i].alu, vecs[i].rs, vecs[i].rt);
      #2;
      chk_outs($sformatf("vec%0d", i), vecs[i].wen, vecs[i].waddr, vecs[i].wdata,
               vecs[i].stall, vecs[i].rsd, vecs[i].rtd);
      @(negedge clk);
    end

    // Reset asserted while the MUL high half is pending
    drive(1, ins(4'hA, 4), 16'h0, 32'h1234_5678, 4, 15);
    #2;
    chk_outs("mulrst.lo", 1, 4, 16'h5678, 1, 16'h5678, 16'h0003);
    @(negedge clk);
    chk("mulrst.hi_pending", 32'(wr_addr_o), 32'd15);
    #1 rst = 1'b0;
    #1;
    chk_outs("mulrst.inrst", 0, 0, 16'h0, 0, 16'h0, 16'h0);
    @(negedge clk); rst = 1'b1;
    drive(1, ins(4'h2, 7), 16'h0, 32'h0000_0042, 7, 15);
    #2;
    chk_outs("mulrst.add", 1, 7, 16'h0042, 0, 16'h0042, 16'h0);
    @(negedge clk);
    drive(0, ins(4'hF, 0), 16'h0, 32'h0, 15, 4);
    #2;
    chk_outs("mulrst.after", 0, 0, 16'h0, 0, 16'h0, 16'h0);
    rs_addr_i = 4'd7; rt_addr_i = 4'd3;
    #1;
    chk("mulrst.r7", 32'(rs_data_o), 32'h0042);
    chk("mulrst.r3", 32'(rt_data_o), 32'h0);

    // Randomized traffic against the model; model starts from the cleared file
    for (int i = 0; i < 16; i++) mregs[i] = (i == 7) ? 16'h0042 : 16'h0;
    pend.delete();
    @(negedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        ewen, estall;
      logic [3:0]  eaddr, op;
      logic [15:0] edata;
      wr_t         w;
      ewen = 0; estall = 0; eaddr = 0; edata = 0;
      if (pend.size() != 0) begin
        w = pend.pop_front();
        ewen = 1; eaddr = w.addr; edata = w.data;
        rs_addr_i = 4'($urandom_range(0, 15));
        rt_addr_i = 4'($urandom_range(0, 15));
      end else begin
        drive(1'($urandom_range(0, 9) != 0), 16'($urandom), 16'($urandom), $urandom,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        op = instr_i[15:12];
        if (valid_i) begin
          if (op <= 4'd7) begin
            ewen = 1; eaddr = instr_i[11:8]; edata = alu_result_i[15:0];
          end else if (op == 4'd8) begin
            ewen = 1; eaddr = instr_i[11:8]; edata = read_data_i;
          end else if (op == 4'd10 || op == 4'd11) begin
            ewen = 1; eaddr = instr_i[11:8]; edata = alu_result_i[15:0]; estall = 1;
            pend.push_back('{4'd15, alu_result_i[31:16]});
          end
        end
      end
      #2;
      chk_outs($sformatf("rand%0d", cyc), ewen, eaddr, edata, estall,
               mread(rs_addr_i, ewen, eaddr, edata), mread(rt_addr_i, ewen, eaddr, edata));
      @(posedge clk);
      if (ewen && eaddr != 4'd0) mregs[eaddr] = edata;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
